// File: rtl/trig_pkg.sv
// Shared constants for the trigger pattern generator: FSM encoding, run modes,
// and a width helper for the bit-index counter.
package trig_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] PTN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic MODE_BURST = 1'b0;
  localparam logic MODE_CONT  = 1'b1;

  function automatic int clog2(input int value);
    int bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/trig_pattern_gen_if.sv
// User control/status bundle of the trigger pattern generator.
interface trig_pattern_gen_if #(
  parameter int PTN_LEN = 4,
  parameter int GAP_W   = 12,
  parameter int NTRIG_W = 16
);

  logic               user_ena;
  logic               user_mode;
  logic [PTN_LEN-2:0] user_trig_ptn;
  logic [GAP_W-1:0]   user_gap;
  logic [NTRIG_W-1:0] user_ntrig;
  logic               trig;
  logic               busy;
  logic               done;
  logic [NTRIG_W-1:0] trig_cnt;

  modport master (
    output user_ena, user_mode, user_trig_ptn, user_gap, user_ntrig,
    input  trig, busy, done, trig_cnt
  );

  modport slave (
    input  user_ena, user_mode, user_trig_ptn, user_gap, user_ntrig,
    output trig, busy, done, trig_cnt
  );

endinterface

// File: rtl/trig_ptn_shift.sv
// Word shifter: loads {header, pattern}, presents the MSB, shifts left and
// flags the cycle in which the last bit is presented.
module trig_ptn_shift
  import trig_pkg::*;
#(
  parameter int PTN_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [PTN_LEN-2:0] ptn,
  output logic               bit_out,
  output logic               last
);

  localparam int IDX_W = clog2(PTN_LEN);

  logic [PTN_LEN-1:0] sreg;
  logic [IDX_W-1:0]   idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= {1'b1, ptn};
      idx  <= IDX_W'(PTN_LEN - 1);
    end else if (shift) begin
      sreg <= {sreg[PTN_LEN-2:0], 1'b0};
      idx  <= idx - IDX_W'(1);
    end
  end

  assign bit_out = sreg[PTN_LEN-1];
  assign last    = (idx == '0);

endmodule

// File: rtl/trig_pattern_gen.sv
// Serial trigger word generator: edge-armed burst/continuous runs of
// header+pattern words separated by a programmable idle gap.
//
// state | meaning
// IDLE  | no run; waiting for a rising edge of user_ena
// GAP   | idle gap before a word, gap_cnt counts down to 1
// PTN   | shifting header and pattern bits onto trig
// DONE  | burst finished; done held until user_ena drops
module trig_pattern_gen
  import trig_pkg::*;
#(
  parameter int PTN_LEN = 4,
  parameter int GAP_W   = 12,
  parameter int NTRIG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  trig_pattern_gen_if.slave bus
);

  logic [1:0]         state, state_nxt;
  logic               ena_q;
  logic               mode_q;
  logic [PTN_LEN-2:0] ptn_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NTRIG_W-1:0] ntrig_q;

  logic               trig_q, busy_q, done_q;
  logic [NTRIG_W-1:0] cnt_q;
  logic               trig_d, busy_d, done_d;
  logic [NTRIG_W-1:0] cnt_d;

  logic               idle_like, start, abort, gap_term, more_words;
  logic [NTRIG_W:0]   cnt_inc;
  logic               sh_load, sh_shift, sh_bit, sh_last;
  logic [PTN_LEN-2:0] sh_ptn;

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign start      = idle_like && bus.user_ena && !ena_q;
  assign abort      = (state != IDLE) && !bus.user_ena;
  assign gap_term   = (gap_cnt == GAP_W'(1));
  assign cnt_inc    = {1'b0, cnt_q} + (NTRIG_W+1)'(1);
  assign more_words = (mode_q == MODE_CONT) || (cnt_inc < {1'b0, ntrig_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (bus.user_mode == MODE_BURST && bus.user_ntrig == '0) state_nxt = DONE;
            else if (bus.user_gap != '0)                             state_nxt = GAP;
            else                                                     state_nxt = PTN;
          end
        end
        GAP: if (gap_term) state_nxt = PTN;
        PTN: begin
          if (sh_last) begin
            if (!more_words)       state_nxt = DONE;
            else if (gap_q != '0)  state_nxt = GAP;
            else                   state_nxt = PTN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; trig lags the shifter by one edge.
  always_comb begin
    trig_d = 1'b0;
    busy_d = busy_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    if (abort) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            cnt_d  = '0;
          end else begin
            busy_d = 1'b0;
            done_d = (state == DONE);
          end
        end
        PTN: begin
          trig_d = sh_bit;
          if (sh_last) cnt_d = cnt_inc[NTRIG_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign sh_load  = (state_nxt == PTN) && ((state != PTN) || sh_last);
  assign sh_shift = (state == PTN);
  assign sh_ptn   = idle_like ? bus.user_trig_ptn : ptn_q;

  trig_ptn_shift #(.PTN_LEN(PTN_LEN)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sh_load),
    .shift   (sh_shift),
    .ptn     (sh_ptn),
    .bit_out (sh_bit),
    .last    (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q   <= 1'b1;
      mode_q  <= MODE_BURST;
      ptn_q   <= '0;
      gap_q   <= '0;
      ntrig_q <= '0;
      gap_cnt <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ena_q  <= bus.user_ena;
      trig_q <= trig_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      if (start) begin
        mode_q  <= bus.user_mode;
        ptn_q   <= bus.user_trig_ptn;
        gap_q   <= bus.user_gap;
        ntrig_q <= bus.user_ntrig;
      end
      if (state_nxt == GAP && state != GAP) gap_cnt <= start ? bus.user_gap : gap_q;
      else if (state == GAP)                gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign bus.trig     = trig_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.trig_cnt = cnt_q;

endmodule

// File: tb/tb_trig_pattern_gen.sv
// Directed bench for trig_pattern_gen: burst vectors from a table, plus
// reset-release, continuous/wrap/abort and mid-word reset sequences.
module tb_trig_pattern_gen;

  localparam int PTN_LEN = 4;
  localparam int GAP_W   = 12;
  localparam int NTRIG_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  trig_pattern_gen_if #(.PTN_LEN(PTN_LEN), .GAP_W(GAP_W), .NTRIG_W(NTRIG_W)) bus ();

  trig_pattern_gen #(.PTN_LEN(PTN_LEN), .GAP_W(GAP_W), .NTRIG_W(NTRIG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // exp_trig bit k = trig after edge E0+k; done is expected from edge E0+done_k on
  typedef struct {
    logic        mode;
    logic [2:0]  ptn;
    logic [11:0] gap;
    logic [3:0]  ntrig;
    logic [31:0] exp_trig;
    logic [3:0]  exp_cnt;
    int          done_k;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_cfg(input logic mode, input logic [2:0] ptn,
                         input logic [11:0] gap, input logic [3:0] ntrig);
    bus.user_mode     = mode;
    bus.user_trig_ptn = ptn;
    bus.user_gap      = gap;
    bus.user_ntrig    = ntrig;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 3'b101, 12'd3, 4'd2, 32'h0000_58B0, 4'd2, 15};
    vecs[1] = '{1'b0, 3'b000, 12'd0, 4'd3, 32'h0000_0222, 4'd3, 13};
    vecs[2] = '{1'b0, 3'b111, 12'd2, 4'd0, 32'h0000_0000, 4'd0, 1};
    vecs[3] = '{1'b0, 3'b011, 12'd1, 4'd1, 32'h0000_0034, 4'd1, 6};
    vecs[4] = '{1'b0, 3'b110, 12'd5, 4'd1, 32'h0000_01C0, 4'd1, 10};
    vecs[5] = '{1'b0, 3'b101, 12'd2, 4'd3, 32'h0005_9658, 4'd3, 19};
    vecs[6] = '{1'b0, 3'b101, 12'd0, 4'd2, 32'h0000_0176, 4'd2, 9};

    bus.user_ena = 1'b1;
    set_cfg(1'b0, 3'b101, 12'd1, 4'd2);
    #2;
    chk("reset_trig", 32'(bus.trig), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_cnt",  32'(bus.trig_cnt), 32'd0);

    // user_ena already high at reset release must not start a run
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("ena_high_release_trig", 32'(bus.trig), 32'd0);
      chk("ena_high_release_busy", 32'(bus.busy), 32'd0);
    end
    bus.user_ena = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      set_cfg(vecs[v].mode, vecs[v].ptn, vecs[v].gap, vecs[v].ntrig);
      bus.user_ena = 1'b1;
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_trig_k%0d", v, k), 32'(bus.trig), 32'(vecs[v].exp_trig[k]));
        chk($sformatf("v%0d_done_k%0d", v, k), 32'(bus.done), 32'(k >= vecs[v].done_k));
        chk($sformatf("v%0d_busy_k%0d", v, k), 32'(bus.busy), 32'(k < vecs[v].done_k));
        if (k == 4) set_cfg(1'b1, ~vecs[v].ptn, 12'd1, 4'd15);
      end
      chk($sformatf("v%0d_cnt", v), 32'(bus.trig_cnt), 32'(vecs[v].exp_cnt));
      bus.user_ena = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done_clear", v), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_cnt_hold", v), 32'(bus.trig_cnt), 32'(vecs[v].exp_cnt));
    end

    // continuous, G=1, ptn=111: period 5, 4-bit count wraps after 16 words
    set_cfg(1'b1, 3'b111, 12'd1, 4'd2);
    bus.user_ena = 1'b1;
    for (int k = 0; k <= 102; k++) begin
      @(negedge clk);
      chk($sformatf("cont_trig_k%0d", k), 32'(bus.trig), 32'((k >= 2) && (((k - 2) % 5) < 4)));
      chk($sformatf("cont_cnt_k%0d", k), 32'(bus.trig_cnt), (k >= 5) ? 32'(((k - 5) / 5 + 1) % 16) : 32'd0);
      chk($sformatf("cont_done_k%0d", k), 32'(bus.done), 32'd0);
    end
    bus.user_ena = 1'b0;
    @(negedge clk);
    chk("abort_trig", 32'(bus.trig), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_cnt",  32'(bus.trig_cnt), 32'd4);

    // reset asserted during the second header of a G=0 burst
    set_cfg(1'b0, 3'b000, 12'd0, 4'd3);
    bus.user_ena = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_trig", 32'(bus.trig), 32'd1);
    chk("pre_reset_cnt",  32'(bus.trig_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_trig", 32'(bus.trig), 32'd0);
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    chk("async_reset_done", 32'(bus.done), 32'd0);
    chk("async_reset_cnt",  32'(bus.trig_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_reset_trig", 32'(bus.trig), 32'd0);
      chk("post_reset_busy", 32'(bus.busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
